// File: rtl/echo_assertion_bank.sv
// Multi-channel assertion stretcher: each trigger holds its channel's assertion for a
// programmable number of cycles, with kill, retrigger policy, countdown readout and event pulses.
module echo_assertion_bank #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 4,
    parameter int IMMEDIATE = 1,
    parameter int MODE      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       trigger,
    input  logic [CHANNELS*CNT_W-1:0] latency,
    input  logic [CHANNELS-1:0]       kill,
    output logic [CHANNELS-1:0]       assertion,
    output logic [CHANNELS*CNT_W-1:0] remaining,
    output logic                      any_assertion,
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS-1:0]       dropped
);

    localparam int              MODE_KEEP   = 1;
    localparam int              MODE_IGNORE = 2;
    localparam logic            IMM_EN      = (IMMEDIATE != 0);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    logic [CHANNELS-1:0][CNT_W-1:0] cnt_r;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_nxt_s;
    logic [CHANNELS-1:0][CNT_W-1:0] lat_s;
    logic [CHANNELS-1:0][CNT_W-1:0] dec_s;
    logic [CHANNELS-1:0]            busy_s;
    logic [CHANNELS-1:0]            expired_nxt_s;
    logic [CHANNELS-1:0]            dropped_nxt_s;

    // Per-channel latency slice, busy flag and saturating decrement
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            lat_s[c]  = latency[c*CNT_W +: CNT_W];
            busy_s[c] = (cnt_r[c] != CNT_ZERO);
            dec_s[c]  = (cnt_r[c] != CNT_ZERO) ? (cnt_r[c] - CNT_ONE) : CNT_ZERO;
        end
    end

    // Next countdown and event pulses: kill beats trigger beats decrement
    always_comb begin
        cnt_nxt_s     = cnt_r;
        expired_nxt_s = '0;
        dropped_nxt_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (kill[c]) begin
                cnt_nxt_s[c] = CNT_ZERO;
            end else if (trigger[c]) begin
                if (!busy_s[c]) begin
                    cnt_nxt_s[c] = lat_s[c];
                end else begin
                    case (MODE)
                        MODE_KEEP: begin
                            cnt_nxt_s[c] = (lat_s[c] > dec_s[c]) ? lat_s[c] : dec_s[c];
                        end
                        MODE_IGNORE: begin
                            cnt_nxt_s[c]     = dec_s[c];
                            dropped_nxt_s[c] = 1'b1;
                        end
                        default: begin
                            cnt_nxt_s[c] = lat_s[c];
                        end
                    endcase
                end
            end else begin
                cnt_nxt_s[c] = dec_s[c];
            end
            // A dropped trigger is not a reload, so a natural expiry still reports
            expired_nxt_s[c] = (cnt_r[c] == CNT_ONE) & ~kill[c]
                             & ~(trigger[c] & ~dropped_nxt_s[c]);
        end
    end

    // Countdown and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            expired <= '0;
            dropped <= '0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            expired <= expired_nxt_s;
            dropped <= dropped_nxt_s;
        end
    end

    // While in reset only the immediate trigger path drives the assertion
    assign assertion     = ({CHANNELS{IMM_EN}} & trigger & ~kill) | (busy_s & {CHANNELS{~rst}});
    assign any_assertion = |assertion;
    assign remaining     = cnt_r;

endmodule

// File: tb/tb_echo_assertion_bank.sv
// Bench for echo_assertion_bank: four parameterisations share one stimulus stream and are
// checked by directed scenarios and a randomized run against a countdown model.
module tb_echo_assertion_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  trigger;
    logic [3:0]  kill;
    logic [15:0] latency;
    logic [3:0]  asr   [4];
    logic [15:0] rem   [4];
    logic        anyo  [4];
    logic [3:0]  expo  [4];
    logic [3:0]  dropo [4];

    int n_cmp = 0;
    int n_bad = 0;

    int mode_of [4] = '{0, 1, 2, 0};
    int imm_of  [4] = '{1, 1, 1, 0};

    always #5 clk = ~clk;

    echo_assertion_bank #(.CHANNELS(4), .CNT_W(4), .IMMEDIATE(1), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .trigger(trigger), .latency(latency), .kill(kill),
        .assertion(asr[0]), .remaining(rem[0]), .any_assertion(anyo[0]),
        .expired(expo[0]), .dropped(dropo[0]));
    echo_assertion_bank #(.CHANNELS(4), .CNT_W(4), .IMMEDIATE(1), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .trigger(trigger), .latency(latency), .kill(kill),
        .assertion(asr[1]), .remaining(rem[1]), .any_assertion(anyo[1]),
        .expired(expo[1]), .dropped(dropo[1]));
    echo_assertion_bank #(.CHANNELS(4), .CNT_W(4), .IMMEDIATE(1), .MODE(2)) dut2 (
        .clk(clk), .rst(rst), .trigger(trigger), .latency(latency), .kill(kill),
        .assertion(asr[2]), .remaining(rem[2]), .any_assertion(anyo[2]),
        .expired(expo[2]), .dropped(dropo[2]));
    echo_assertion_bank #(.CHANNELS(4), .CNT_W(4), .IMMEDIATE(0), .MODE(0)) dut3 (
        .clk(clk), .rst(rst), .trigger(trigger), .latency(latency), .kill(kill),
        .assertion(asr[3]), .remaining(rem[3]), .any_assertion(anyo[3]),
        .expired(expo[3]), .dropped(dropo[3]));

    task automatic set_in(input logic [3:0] t, input logic [15:0] l, input logic [3:0] k,
                          input logic r);
        trigger = t;
        latency = l;
        kill    = k;
        rst     = r;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(4'b0000, 16'h0000, 4'b0000, 1'b1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_in(4'b0010, 16'h0050, 4'b0000, 1'b1);
        for (int d = 0; d < 4; d++) begin
            n_cmp += 4;
            if (rem[d] !== 16'h0000) begin
                n_bad++; $display("FAIL reset_remaining dut%0d got=%h exp=0000", d, rem[d]);
            end
            if (expo[d] !== 4'b0000) begin
                n_bad++; $display("FAIL reset_expired dut%0d got=%b exp=0000", d, expo[d]);
            end
            if (dropo[d] !== 4'b0000) begin
                n_bad++; $display("FAIL reset_dropped dut%0d got=%b exp=0000", d, dropo[d]);
            end
            if (asr[d] !== ((imm_of[d] != 0) ? 4'b0010 : 4'b0000)) begin
                n_bad++; $display("FAIL reset_imm_assert dut%0d got=%b", d, asr[d]);
            end
        end
        tick();
        set_in(4'b0000, 16'h0000, 4'b0000, 1'b0);
        for (int d = 0; d < 4; d++) begin
            n_cmp += 2;
            if (asr[d] !== 4'b0000) begin
                n_bad++; $display("FAIL post_reset_assert dut%0d got=%b exp=0000", d, asr[d]);
            end
            if (rem[d] !== 16'h0000) begin
                n_bad++; $display("FAIL post_reset_remaining dut%0d got=%h exp=0000", d, rem[d]);
            end
        end
        tick();
    endtask

    task automatic test_single();
        int ea [6] = '{1, 1, 1, 1, 0, 0};
        int er [6] = '{0, 3, 2, 1, 0, 0};
        int ee [6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_in((k == 0) ? 4'b0001 : 4'b0000, 16'h0003, 4'b0000, 1'b0);
            n_cmp += 3;
            if (asr[0] !== 4'(ea[k])) begin
                n_bad++; $display("FAIL single_assert cyc=%0d got=%b exp=%0d", k, asr[0], ea[k]);
            end
            if (rem[0] !== 16'(er[k])) begin
                n_bad++; $display("FAIL single_remaining cyc=%0d got=%h exp=%0d", k, rem[0], er[k]);
            end
            if (expo[0] !== 4'(ee[k])) begin
                n_bad++; $display("FAIL single_expired cyc=%0d got=%b exp=%0d", k, expo[0], ee[k]);
            end
            tick();
        end
    endtask

    task automatic test_retrigger();
        int ea [7] = '{1, 1, 1, 1, 1, 0, 0};
        int er [7] = '{0, 3, 2, 2, 1, 0, 0};
        int ee [7] = '{0, 0, 0, 0, 0, 1, 0};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            set_in((k == 0 || k == 2) ? 4'b0001 : 4'b0000,
                   (k == 2) ? 16'h0002 : 16'h0003, 4'b0000, 1'b0);
            n_cmp += 3;
            if (asr[0] !== 4'(ea[k])) begin
                n_bad++; $display("FAIL retrig_assert cyc=%0d got=%b exp=%0d", k, asr[0], ea[k]);
            end
            if (rem[0] !== 16'(er[k])) begin
                n_bad++; $display("FAIL retrig_remaining cyc=%0d got=%h exp=%0d", k, rem[0], er[k]);
            end
            if (expo[0] !== 4'(ee[k])) begin
                n_bad++; $display("FAIL retrig_expired cyc=%0d got=%b exp=%0d", k, expo[0], ee[k]);
            end
            tick();
        end
    endtask

    task automatic test_policy();
        int ea [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        int er [8] = '{0, 5, 4, 3, 2, 1, 0, 0};
        int ed [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        int ee [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_in((k < 2) ? 4'b0001 : 4'b0000, (k == 1) ? 16'h0002 : 16'h0005,
                   4'b0000, 1'b0);
            for (int d = 1; d < 3; d++) begin
                n_cmp += 4;
                if (asr[d] !== 4'(ea[k])) begin
                    n_bad++; $display("FAIL policy_assert dut%0d cyc=%0d got=%b exp=%0d", d, k, asr[d], ea[k]);
                end
                if (rem[d] !== 16'(er[k])) begin
                    n_bad++; $display("FAIL policy_remaining dut%0d cyc=%0d got=%h exp=%0d", d, k, rem[d], er[k]);
                end
                if (expo[d] !== 4'(ee[k])) begin
                    n_bad++; $display("FAIL policy_expired dut%0d cyc=%0d got=%b exp=%0d", d, k, expo[d], ee[k]);
                end
                if (dropo[d] !== ((d == 2) ? 4'(ed[k]) : 4'b0000)) begin
                    n_bad++; $display("FAIL policy_dropped dut%0d cyc=%0d got=%b", d, k, dropo[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_kill();
        int ea [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        int er [8] = '{0, 7, 6, 5, 0, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_in((k == 0 || k == 6) ? 4'b0001 : 4'b0000, (k == 6) ? 16'h0005 : 16'h0007,
                   (k == 3 || k == 6) ? 4'b0001 : 4'b0000, 1'b0);
            n_cmp += 4;
            if (asr[0] !== 4'(ea[k])) begin
                n_bad++; $display("FAIL kill_assert cyc=%0d got=%b exp=%0d", k, asr[0], ea[k]);
            end
            if (rem[0] !== 16'(er[k])) begin
                n_bad++; $display("FAIL kill_remaining cyc=%0d got=%h exp=%0d", k, rem[0], er[k]);
            end
            if (expo[0] !== 4'b0000) begin
                n_bad++; $display("FAIL kill_expired cyc=%0d got=%b exp=0000", k, expo[0]);
            end
            if (dropo[2] !== 4'b0000) begin
                n_bad++; $display("FAIL kill_dropped cyc=%0d got=%b exp=0000", k, dropo[2]);
            end
            tick();
        end
    endtask

    task automatic test_edges();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in((k == 0) ? 4'b0001 : 4'b0000, 16'h0000, 4'b0000, 1'b0);
            n_cmp += 4;
            if (asr[3] !== 4'b0000) begin
                n_bad++; $display("FAIL zero_lat_noimm_assert cyc=%0d got=%b exp=0000", k, asr[3]);
            end
            if (asr[0] !== ((k == 0) ? 4'b0001 : 4'b0000)) begin
                n_bad++; $display("FAIL zero_lat_imm_assert cyc=%0d got=%b", k, asr[0]);
            end
            if (rem[0] !== 16'h0000) begin
                n_bad++; $display("FAIL zero_lat_remaining cyc=%0d got=%h exp=0000", k, rem[0]);
            end
            if (expo[0] !== 4'b0000) begin
                n_bad++; $display("FAIL zero_lat_expired cyc=%0d got=%b exp=0000", k, expo[0]);
            end
            tick();
        end
        do_reset();
        for (int k = 0; k < 18; k++) begin
            set_in((k == 0) ? 4'b0001 : 4'b0000, 16'h000F, 4'b0000, 1'b0);
            n_cmp += 4;
            if (asr[0] !== ((k <= 15) ? 4'b0001 : 4'b0000)) begin
                n_bad++; $display("FAIL max_lat_assert cyc=%0d got=%b", k, asr[0]);
            end
            if (asr[3] !== ((k >= 1 && k <= 15) ? 4'b0001 : 4'b0000)) begin
                n_bad++; $display("FAIL max_lat_noimm_assert cyc=%0d got=%b", k, asr[3]);
            end
            if (rem[0] !== ((k >= 1 && k <= 15) ? 16'(16 - k) : 16'h0000)) begin
                n_bad++; $display("FAIL max_lat_remaining cyc=%0d got=%h", k, rem[0]);
            end
            if (expo[0] !== ((k == 16) ? 4'b0001 : 4'b0000)) begin
                n_bad++; $display("FAIL max_lat_expired cyc=%0d got=%b", k, expo[0]);
            end
            tick();
        end
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in((k == 0) ? 4'b0001 : 4'b0000, 16'h0006, 4'b0000, (k == 2) ? 1'b1 : 1'b0);
            if (k >= 2) begin
                for (int d = 0; d < 4; d++) begin
                    n_cmp += 1;
                    if (asr[d] !== 4'b0000) begin
                        n_bad++; $display("FAIL rst_mid_assert dut%0d cyc=%0d got=%b exp=0000", d, k, asr[d]);
                    end
                    if (k >= 3) begin
                        n_cmp += 3;
                        if (rem[d] !== 16'h0000) begin
                            n_bad++; $display("FAIL rst_mid_remaining dut%0d cyc=%0d got=%h exp=0000", d, k, rem[d]);
                        end
                        if (expo[d] !== 4'b0000) begin
                            n_bad++; $display("FAIL rst_mid_expired dut%0d cyc=%0d got=%b exp=0000", d, k, expo[d]);
                        end
                        if (dropo[d] !== 4'b0000) begin
                            n_bad++; $display("FAIL rst_mid_dropped dut%0d cyc=%0d got=%b exp=0000", d, k, dropo[d]);
                        end
                    end
                end
            end
            tick();
        end
    endtask

    // Model: each channel is just "cycles of hold left", updated from the retrigger rules
    task automatic test_random();
        int   m_rem  [4][4];
        bit   m_exp  [4][4];
        bit   m_drop [4][4];
        int   lat;
        int   r;
        logic [3:0]  ea, ee, ed;
        logic [15:0] er;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_rem[d][c] = 0; m_exp[d][c] = 1'b0; m_drop[d][c] = 1'b0;
            end
        end
        for (int n = 0; n < 10000; n++) begin
            logic [3:0] t, k;
            for (int c = 0; c < 4; c++) begin
                t[c] = ($urandom_range(0, 3) == 0);
                k[c] = ($urandom_range(0, 15) == 0);
            end
            set_in(t, 16'($urandom), k, ($urandom_range(0, 199) == 0));
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    ea[c] = ((imm_of[d] != 0) && trigger[c] && !kill[c]) || (!rst && m_rem[d][c] > 0);
                    er[c*4 +: 4] = 4'(m_rem[d][c]);
                    ee[c] = m_exp[d][c];
                    ed[c] = m_drop[d][c];
                end
                n_cmp += 5;
                if (asr[d] !== ea) begin
                    n_bad++; $display("FAIL rand_assert dut%0d n=%0d got=%b exp=%b", d, n, asr[d], ea);
                end
                if (anyo[d] !== (|ea)) begin
                    n_bad++; $display("FAIL rand_any dut%0d n=%0d got=%b exp=%b", d, n, anyo[d], |ea);
                end
                if (rem[d] !== er) begin
                    n_bad++; $display("FAIL rand_remaining dut%0d n=%0d got=%h exp=%h", d, n, rem[d], er);
                end
                if (expo[d] !== ee) begin
                    n_bad++; $display("FAIL rand_expired dut%0d n=%0d got=%b exp=%b", d, n, expo[d], ee);
                end
                if (dropo[d] !== ed) begin
                    n_bad++; $display("FAIL rand_dropped dut%0d n=%0d got=%b exp=%b", d, n, dropo[d], ed);
                end
                for (int c = 0; c < 4; c++) begin
                    lat = int'(latency[c*4 +: 4]);
                    r   = m_rem[d][c];
                    m_exp[d][c]  = 1'b0;
                    m_drop[d][c] = 1'b0;
                    if (rst || kill[c]) begin
                        m_rem[d][c] = 0;
                    end else if (trigger[c] && r == 0) begin
                        m_rem[d][c] = lat;
                    end else if (trigger[c] && mode_of[d] == 1) begin
                        m_rem[d][c] = (lat > r - 1) ? lat : r - 1;
                    end else if (trigger[c] && mode_of[d] == 2) begin
                        m_rem[d][c]  = r - 1;
                        m_drop[d][c] = 1'b1;
                        m_exp[d][c]  = (r == 1);
                    end else if (trigger[c]) begin
                        m_rem[d][c] = lat;
                    end else begin
                        m_rem[d][c] = (r > 0) ? r - 1 : 0;
                        m_exp[d][c] = (r == 1);
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_in(4'b0000, 16'h0000, 4'b0000, 1'b1);
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_retrigger();
        test_policy();
        test_kill();
        test_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
